// File: rtl/fifo_flex_if.sv
// Bundle of the FIFO's data path, status flags and error controls.
// The producer/consumer side uses the master modport; the FIFO itself uses slave.
interface fifo_flex_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, din, rd_en, clr_err,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, clr_err,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_flex.sv
// Synchronous FIFO with arbitrary (non power-of-two) depth, selectable
// registered-read or first-word-fall-through output, occupancy flags derived
// only from the registered count, and sticky overflow/underflow flags.
module fifo_flex #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input logic        clk,
  input logic        rst,
  fifo_flex_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

  // Storage: no reset, contents are meaningless until written.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic full_w;
  logic empty_w;
  logic wr_accept;
  logic rd_accept;

  // Pointer increment with explicit wrap so any DEPTH works.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Status flags depend only on the registered count, never on wr_en/rd_en.
  always_comb begin
    full_w           = (count_q == DEPTH_C);
    empty_w          = (count_q == '0);
    bus.full         = full_w;
    bus.empty        = empty_w;
    bus.almost_full  = (count_q >= AF_C);
    bus.almost_empty = (count_q <= AE_C);
  end

  // A read frees a slot only at the edge, so a write while full is always
  // rejected even if a read is accepted in the same cycle (and vice versa
  // when empty).
  assign wr_accept = bus.wr_en && !full_w;
  assign rd_accept = bus.rd_en && !empty_w;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_accept) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (rd_accept) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A new error event outranks a simultaneous clear.
    overflow_d = overflow_q;
    if (bus.clr_err) begin
      overflow_d = 1'b0;
    end
    if (bus.wr_en && full_w) begin
      overflow_d = 1'b1;
    end

    underflow_d = underflow_q;
    if (bus.clr_err) begin
      underflow_d = 1'b0;
    end
    if (bus.rd_en && empty_w) begin
      underflow_d = 1'b1;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Output register always tracks the head word after this edge; when
      // the new head is the slot being written right now, take it from din.
      always_comb begin
        dout_d = mem_q[rd_ptr_d];
        if (wr_accept && (rd_ptr_d == wr_ptr_q)) begin
          dout_d = bus.din;
        end
      end
    end else begin : g_std
      // Output register loads the head word only when a pop is accepted.
      always_comb begin
        dout_d = dout_q;
        if (rd_accept) begin
          dout_d = mem_q[rd_ptr_q];
        end
      end
    end
  endgenerate

  // Control state; reset discards all stored words at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= bus.din;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex: one default registered-read instance
// (DEPTH=32) and one DEPTH=5 first-word-fall-through instance.
module tb_fifo_flex;

  logic clk;
  logic rst0;
  logic rst1;

  int n_tests;
  int n_fail;

  logic [7:0] q1 [$];

  fifo_flex_if #(.WIDTH(8), .DEPTH(32)) f0 ();
  fifo_flex_if #(.WIDTH(8), .DEPTH(5))  f1 ();

  fifo_flex #(.WIDTH(8), .DEPTH(32), .FWFT(0)) u_dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (f0)
  );

  fifo_flex #(.WIDTH(8), .DEPTH(5), .FWFT(1)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (f1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the FWFT instance for one cycle and compare against a queue model.
  task automatic drive1(input logic wr, input logic rd, input logic [7:0] d, input string tag);
    int  sz;
    logic wa;
    logic ra;
    f1.wr_en = wr;
    f1.rd_en = rd;
    f1.din   = d;
    step();
    sz = q1.size();
    wa = wr && (sz < 5);
    ra = rd && (sz > 0);
    if (ra) void'(q1.pop_front());
    if (wa) q1.push_back(d);
    chk({tag, "_count"}, 32'(f1.count), 32'(q1.size()));
    if (q1.size() > 0) chk({tag, "_dout"}, 32'(f1.dout), 32'(q1[0]));
    $display("[TB] dut1 %s wr=%0b rd=%0b din=%0h count=%0d dout=%0h", tag, wr, rd, d, f1.count, f1.dout);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    f0.wr_en = 1'b0; f0.rd_en = 1'b0; f0.clr_err = 1'b0; f0.din = '0;
    f1.wr_en = 1'b0; f1.rd_en = 1'b0; f1.clr_err = 1'b0; f1.din = '0;
    step();
    step();

    // ---------------- reset state ----------------
    chk("rst_empty", 32'(f0.empty), 1);
    chk("rst_full", 32'(f0.full), 0);
    chk("rst_ae", 32'(f0.almost_empty), 1);
    chk("rst_af", 32'(f0.almost_full), 0);
    chk("rst_count", 32'(f0.count), 0);
    chk("rst_dout", 32'(f0.dout), 0);
    chk("rst_ovf", 32'(f0.overflow), 0);
    chk("rst_udf", 32'(f0.underflow), 0);
    chk("rst1_empty", 32'(f1.empty), 1);
    chk("rst1_count", 32'(f1.count), 0);

    @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;

    // ---------------- fill 32 words ----------------
    for (int i = 1; i <= 32; i++) begin
      f0.wr_en = 1'b1;
      f0.din   = 8'(i);
      step();
      $display("[TB] dut0 write din=%0h count=%0d af=%0b full=%0b", 8'(i), f0.count, f0.almost_full, f0.full);
      chk($sformatf("fill_count_%0d", i), 32'(f0.count), 32'(i));
      chk($sformatf("fill_af_%0d", i), 32'(f0.almost_full), (i >= 28) ? 1 : 0);
      chk($sformatf("fill_full_%0d", i), 32'(f0.full), (i == 32) ? 1 : 0);
    end

    // 33rd write is rejected
    f0.din = 8'h21;
    step();
    $display("[TB] dut0 write-at-full din=21 count=%0d ovf=%0b", f0.count, f0.overflow);
    chk("ovf_count", 32'(f0.count), 32);
    chk("ovf_flag", 32'(f0.overflow), 1);
    chk("ovf_full", 32'(f0.full), 1);

    // clear, then clear coinciding with a new overflow
    f0.wr_en   = 1'b0;
    f0.clr_err = 1'b1;
    step();
    $display("[TB] dut0 clr_err ovf=%0b", f0.overflow);
    chk("clr_ovf", 32'(f0.overflow), 0);
    f0.wr_en = 1'b1;
    f0.din   = 8'h99;
    step();
    $display("[TB] dut0 clr_err+write-at-full ovf=%0b count=%0d", f0.overflow, f0.count);
    chk("clr_vs_ovf", 32'(f0.overflow), 1);
    chk("clr_vs_ovf_count", 32'(f0.count), 32);
    f0.wr_en   = 1'b0;
    f0.clr_err = 1'b0;

    // ---------------- drain 32 words ----------------
    f0.rd_en = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      $display("[TB] dut0 read dout=%0h count=%0d", f0.dout, f0.count);
      chk($sformatf("drain_dout_%0d", i), 32'(f0.dout), 32'(i));
      chk($sformatf("drain_count_%0d", i), 32'(f0.count), 32'(32 - i));
    end
    chk("drain_empty", 32'(f0.empty), 1);
    chk("drain_ae", 32'(f0.almost_empty), 1);

    // read on empty: rejected, dout holds
    step();
    $display("[TB] dut0 read-at-empty udf=%0b dout=%0h", f0.underflow, f0.dout);
    chk("udf_flag", 32'(f0.underflow), 1);
    chk("udf_dout_hold", 32'(f0.dout), 32'h20);
    chk("udf_count", 32'(f0.count), 0);
    f0.rd_en   = 1'b0;
    f0.clr_err = 1'b1;
    step();
    $display("[TB] dut0 clr_err udf=%0b", f0.underflow);
    chk("clr_udf", 32'(f0.underflow), 0);
    f0.clr_err = 1'b0;

    // ---------------- full with simultaneous rd/wr ----------------
    f0.wr_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      f0.din = 8'(8'h40 + i);
      step();
    end
    chk("refill_full", 32'(f0.full), 1);
    f0.rd_en = 1'b1;
    f0.din   = 8'hEE;
    step();
    $display("[TB] dut0 rd+wr at full count=%0d dout=%0h ovf=%0b", f0.count, f0.dout, f0.overflow);
    chk("fullrw_count", 32'(f0.count), 31);
    chk("fullrw_ovf", 32'(f0.overflow), 1);
    chk("fullrw_dout", 32'(f0.dout), 32'h40);
    f0.wr_en = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      step();
      chk($sformatf("fullrw_drain_%0d", i), 32'(f0.dout), 32'(8'h40 + i));
    end
    f0.rd_en = 1'b0;
    chk("fullrw_empty", 32'(f0.empty), 1);

    // ---------------- asynchronous reset mid-operation ----------------
    f0.wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      f0.din = 8'(8'h70 + i);
      step();
    end
    f0.wr_en = 1'b0;
    chk("pre_rst_count", 32'(f0.count), 10);
    #3;
    rst0 = 1'b1;
    #1;
    $display("[TB] dut0 async reset empty=%0b count=%0d dout=%0h", f0.empty, f0.count, f0.dout);
    chk("arst_empty", 32'(f0.empty), 1);
    chk("arst_count", 32'(f0.count), 0);
    chk("arst_dout", 32'(f0.dout), 0);
    chk("arst_ovf", 32'(f0.overflow), 0);
    chk("arst_full", 32'(f0.full), 0);
    @(negedge clk);
    rst0 = 1'b0;
    f0.wr_en = 1'b1;
    f0.din   = 8'h3C;
    step();
    f0.wr_en = 1'b0;
    f0.rd_en = 1'b1;
    step();
    f0.rd_en = 1'b0;
    $display("[TB] dut0 post-reset write/read dout=%0h", f0.dout);
    chk("post_rst_dout", 32'(f0.dout), 32'h3C);
    chk("post_rst_empty", 32'(f0.empty), 1);

    // ---------------- FWFT instance, DEPTH=5 ----------------
    drive1(1'b1, 1'b1, 8'hA5, "empty_rdwr");
    chk("fw_udf", 32'(f1.underflow), 1);
    chk("fw_a5", 32'(f1.dout), 32'hA5);
    chk("fw_nonempty", 32'(f1.empty), 0);
    for (int k = 0; k < 3; k++) drive1(1'b1, 1'b1, 8'(8'hB0 + k), $sformatf("rdwr_%0d", k));
    for (int k = 0; k < 3; k++) drive1(1'b1, 1'b0, 8'(8'hC0 + k), $sformatf("fill_%0d", k));
    for (int k = 3; k < 12; k++) drive1(1'b1, 1'b1, 8'(8'hC0 + k), $sformatf("stream_%0d", k));
    drive1(1'b1, 1'b0, 8'hD0, "top_up");
    chk("fw_full", 32'(f1.full), 1);
    chk("fw_af", 32'(f1.almost_full), 1);
    chk("fw_ae", 32'(f1.almost_empty), 0);
    drive1(1'b1, 1'b1, 8'hD1, "full_rdwr");
    chk("fw_ovf", 32'(f1.overflow), 1);
    for (int k = 0; k < 4; k++) drive1(1'b0, 1'b1, 8'h00, $sformatf("drain_%0d", k));
    chk("fw_empty", 32'(f1.empty), 1);
    f1.rd_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
